// File: rtl/fir_pkg.sv
// Shared sizing and output-scaling helpers for the systolic FIR filter.
package fir_pkg;

  function automatic int fir_acc_w(input int data_w, input int coef_w, input int num_taps);
    return data_w + coef_w + $clog2(num_taps);
  endfunction

  function automatic logic signed [63:0] data_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] data_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Round half up, then arithmetic shift; frac_bits = 0 passes the value through.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] value,
                                                     input int frac_bits);
    logic signed [63:0] r;
    if (frac_bits > 0) begin
      r = (value + (64'sd1 <<< (frac_bits - 1))) >>> frac_bits;
    end else begin
      r = value;
    end
    return r;
  endfunction

  function automatic logic signed [63:0] sat_round(input logic signed [63:0] value,
                                                   input int frac_bits, input int out_w);
    logic signed [63:0] r;
    r = round_shift(value, frac_bits);
    if (r > data_max(out_w)) begin
      r = data_max(out_w);
    end else if (r < data_min(out_w)) begin
      r = data_min(out_w);
    end else begin
      r = r;
    end
    return r;
  endfunction

  function automatic logic sat_hit(input logic signed [63:0] value,
                                   input int frac_bits, input int out_w);
    logic signed [63:0] r;
    r = round_shift(value, frac_bits);
    return (r > data_max(out_w)) || (r < data_min(out_w));
  endfunction

endpackage

// File: rtl/fir_tap_mac.sv
// One transposed-form tap: s <= s_in + x*h on advance, flushed by clr.
module fir_tap_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = 17,
  parameter int COEF_W = 17,
  parameter int ACC_W  = 36
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     adv_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [COEF_W-1:0] h_i,
  input  logic signed [ACC_W-1:0]  s_i,
  output logic signed [ACC_W-1:0]  s_o
);

  logic signed [ACC_W-1:0] mac_s;
  logic signed [ACC_W-1:0] s_d, s_q;

  assign mac_s = ACC_W'(x_i) * ACC_W'(h_i) + s_i;
  assign s_o   = s_q;

  always_comb begin
    s_d = s_q;
    if (clr_i) begin
      s_d = '0;
    end else if (adv_i) begin
      s_d = mac_s;
    end else begin
      s_d = s_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

endmodule

// File: rtl/fir_systolic_pipeline.sv
// Transposed-form FIR with runtime coefficients, rounding/saturating output
// register and valid/ready flow control.
module fir_systolic_pipeline
  import fir_pkg::*;
#(
  parameter int NUM_TAPS  = 4,
  parameter int DATA_W    = 17,
  parameter int COEF_W    = 17,
  parameter int FRAC_BITS = 16,
  parameter int ADDR_W    = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     coef_we_i,
  input  logic [ADDR_W-1:0]        coef_addr_i,
  input  logic signed [COEF_W-1:0] coef_data_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic signed [DATA_W-1:0] x_in_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic signed [DATA_W-1:0] y_out_o,
  output logic                     out_sat_o
);

  localparam int ACC_W = fir_acc_w(DATA_W, COEF_W, NUM_TAPS);

  logic signed [COEF_W-1:0] h_d [NUM_TAPS];
  logic signed [COEF_W-1:0] h_q [NUM_TAPS];
  logic signed [ACC_W-1:0]  s_w [1:NUM_TAPS];
  logic signed [ACC_W-1:0]  full_s;
  logic                     adv_s;
  logic signed [DATA_W-1:0] y_d, y_q;
  logic                     vld_d, vld_q;
  logic                     sat_d, sat_q;

  assign in_ready_o  = rst_ni && !clr_i && (!vld_q || out_ready_i);
  assign adv_s       = in_valid_i && in_ready_o;
  assign out_valid_o = vld_q;
  assign y_out_o     = y_q;
  assign out_sat_o   = sat_q;

  // The last tap has no upstream partial sum.
  assign s_w[NUM_TAPS] = '0;

  for (genvar k = 1; k < NUM_TAPS; k++) begin : g_tap
    fir_tap_mac #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W)
    ) u_tap (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (clr_i),
      .adv_i  (adv_s),
      .x_i    (x_in_i),
      .h_i    (h_q[k]),
      .s_i    (s_w[k+1]),
      .s_o    (s_w[k])
    );
  end

  assign full_s = ACC_W'(x_in_i) * ACC_W'(h_q[0]) + s_w[1];

  always_comb begin
    h_d = h_q;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (coef_we_i && (coef_addr_i == ADDR_W'(k))) begin
        h_d[k] = coef_data_i;
      end else begin
        h_d[k] = h_q[k];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        h_q[k] <= '0;
      end
    end else begin
      h_q <= h_d;
    end
  end

  // clr wins over advance, and advance wins over the output handshake.
  always_comb begin
    y_d   = y_q;
    vld_d = vld_q;
    sat_d = sat_q;
    if (clr_i) begin
      y_d   = '0;
      vld_d = 1'b0;
      sat_d = 1'b0;
    end else if (adv_s) begin
      y_d   = DATA_W'(sat_round(64'(full_s), FRAC_BITS, DATA_W));
      sat_d = sat_hit(64'(full_s), FRAC_BITS, DATA_W);
      vld_d = 1'b1;
    end else if (out_ready_i) begin
      vld_d = 1'b0;
    end else begin
      vld_d = vld_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      y_q   <= '0;
      vld_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      vld_q <= vld_d;
      sat_q <= sat_d;
    end
  end

endmodule

// File: doc/fir_systolic_pipeline.md
Name: fir_systolic_pipeline

Overview:
- Parametrised transposed-form FIR filter built from a chain of signed fixed-point multiply-accumulate taps.
- Each tap is the next generation of the single-tap MAC unit. Additions over that unit:
  - configurable data, coefficient and tap widths;
  - run-time coefficient loading;
  - round-and-shift output scaling;
  - valid/ready flow control with backpressure;
  - a saturation indicator.
- Sits in the image-kernel datapath between the pixel streamer and the writeback stage.

Parameters:
- NUM_TAPS, 4, number of filter taps (>=2).
- DATA_W, 17, signed sample and output width.
- COEF_W, 17, signed coefficient width.
- FRAC_BITS, 16, coefficient fractional bits; result is right-shifted by this amount with rounding (0 = no shift, no rounding).
- ADDR_W, 2, coefficient address width; requires 2^ADDR_W >= NUM_TAPS.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous flush of partial sums and output stage.
- coef_we  input  1  coefficient write strobe.
- coef_addr  input  ADDR_W  tap index to write.
- coef_data  input  COEF_W  signed coefficient value.
- in_valid  input  1  sample valid.
- in_ready  output  1  block can accept a sample this cycle.
- x_in  input  DATA_W  signed input sample.
- out_valid  output  1  y_out holds a result.
- out_ready  input  1  downstream accepts the result.
- y_out  output  DATA_W  filtered, scaled, saturated sample.
- out_sat  output  1  y_out was clamped; qualified by out_valid.

Behaviour:
- Reset (rst low, asynchronous): the following are cleared to 0 immediately:
  - all coefficients;
  - all partial sums;
  - y_out, out_valid, out_sat.
- in_ready is a combinational output. It is 0 while in reset.
- Internal accumulator width: ACC_W = DATA_W + COEF_W + clog2(NUM_TAPS). Partial sums never overflow, so no intermediate saturation is applied.
- in_ready = !clr && (!out_valid || out_ready).
- A sample is accepted when in_valid && in_ready. This is the "advance" condition. On advance:
  - s[k] <= s[k+1] + x_in*h[k] for k = 1..NUM_TAPS-2;
  - s[NUM_TAPS-1] <= x_in*h[NUM_TAPS-1];
  - full = x_in*h[0] + s[1].
- Scaling of full:
  - FRAC_BITS > 0: r = (full + 2^(FRAC_BITS-1)) >>> FRAC_BITS, arithmetic shift (round half up).
  - FRAC_BITS = 0: r = full.
- Saturation of r to DATA_W signed:
  - r > 2^(DATA_W-1)-1: y_out = max, out_sat = 1.
  - r < -2^(DATA_W-1): y_out = min, out_sat = 1.
  - otherwise y_out = r[DATA_W-1:0], out_sat = 0.
  - For DATA_W = 17 the limits are 0x0ffff and 0x10000.
- Latency: y_out and out_valid are registered 1 cycle after acceptance. Throughput is 1 sample/cycle while out_ready = 1.
- Output handshake:
  - out_valid is set on advance.
  - out_valid is cleared when out_ready = 1 and there is no advance in the same cycle.
  - While out_valid && !out_ready: y_out and out_sat are held and the partial sums are frozen.
- Coefficient writes:
  - coef_we writes h[coef_addr] <= coef_data; the new value is visible from the next cycle.
  - A write and an advance in the same cycle: the sample uses the old coefficient.
  - coef_addr >= NUM_TAPS: the write is ignored.
  - Writes are allowed at any time, including while stalled.
- clr (synchronous):
  - zeroes all partial sums;
  - clears out_valid and out_sat; y_out is zeroed;
  - coefficients are retained;
  - forces in_ready = 0, so no sample is accepted in that cycle;
  - clr has priority over advance and over output handshake.
- Reset asserted mid-stream: all state is lost, including coefficients. Software must reload the coefficients.

Decomposition:
- Shared package fir_pkg holds:
  - function sat_round(value, frac_bits, out_w);
  - localparam ACC_W derivation;
  - DATA_MAX / DATA_MIN constant functions.
- Sub-module fir_tap_mac: one tap, combinational x*h + s_in at ACC_W plus the s register with advance/clr enables. Instantiated NUM_TAPS-1 times via generate.
- Tap 0 product, rounding, saturation and the output register live in the top level.

Test Plan:
All scenarios use defaults (NUM_TAPS=4, DATA_W=17, FRAC_BITS=16).
- Impulse:
  - Stimulus: load h = {0x08000, 0x04000, 0x02000, 0x01000}; send x = 0x08000 then zeros, out_ready = 1.
  - Response: y_out = 0x04000, 0x02000, 0x01000, 0x00800, then 0; each out_valid one cycle after acceptance; out_sat = 0.
- Positive saturation:
  - Stimulus: all h = 0x0ffff; x = 0x0ffff repeated.
  - Response: 1st y_out = 0x0fffe with out_sat = 0; 2nd onward y_out = 0x0ffff with out_sat = 1.
- Negative saturation:
  - Stimulus: all h = 0x0ffff; x = 0x10000 repeated.
  - Response: 1st y_out = 0x10001; 2nd onward y_out = 0x10000 with out_sat = 1.
- Backpressure:
  - Stimulus: out_ready = 0 for 5 cycles with in_valid = 1 during the impulse test.
  - Response: in_ready = 0; y_out and out_valid held; resuming gives the identical output sequence with no samples lost or duplicated.
- Coefficient write collision and bad address:
  - Stimulus: write h[0] = 0x04000 in the same cycle as x = 0x08000 (old h[0] = 0x08000); separately write to coef_addr = 4 when ADDR_W = 3.
  - Response: that output uses 0x08000, giving y_out = 0x04000; the next impulse gives 0x02000; the address-4 write has no effect.
- clr and reset:
  - Stimulus: clr mid-impulse while in_valid = 1.
  - Response: sample not accepted; partial sums zeroed; out_valid = 0; the next impulse output is clean.
  - Stimulus: rst low mid-stream.
  - Response: all outputs 0 immediately; coefficients read as 0 (all-zero output afterwards).
